alu_lane_sequencer: RTL and testbench

Sequences one shared scalar ALU across the lanes of a vector operation in the Filter-GPU vector unit. It accepts a whole vector instruction (opcode plus two packed operand vectors) through a valid/ready handshake. It issues one lane per cycle to the external combinational scalar ALU and gathers the per-lane results into a packed result vector. It then presents that vector with reduced flags through a second valid/ready handshake.

---
 rtl/alu_lane_sequencer.sv | 122 ++++++++++++
 tb/tb_alu_lane_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_lane_sequencer.sv
// Serialises one vector instruction over a shared combinational scalar ALU, one lane
// per cycle, and returns the packed per-lane results with reduced flags.
module alu_lane_sequencer #(
  parameter int N     = 18,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [LANES*N-1:0] in_a,
  input  logic [LANES*N-1:0] in_b,
  output logic [N-1:0]       alu_a,
  output logic [N-1:0]       alu_b,
  output logic [2:0]         alu_f,
  input  logic [N-1:0]       alu_result,
  input  logic               alu_negative,
  input  logic               alu_zero,
  input  logic               alu_carry,
  input  logic               alu_overflow,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] out_result,
  output logic               out_zero,
  output logic               out_negative,
  output logic               out_carry,
  output logic               out_overflow,
  output logic               busy
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic [N-1:0]  a_q   [LANES];
  logic [N-1:0]  b_q   [LANES];
  logic [N-1:0]  res_q [LANES];

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make the lane write and the count race.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      op_q         <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      out_zero     <= 1'b0;
      out_negative <= 1'b0;
      out_carry    <= 1'b0;
      out_overflow <= 1'b0;
      // NOTE: only the visible result lanes are reset; a_q/b_q are always loaded on
      // accept before they are read, so resetting them would buy nothing.
      for (int i = 0; i < LANES; i++) res_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q         <= in_op;
            cnt          <= '0;
            out_zero     <= 1'b1;
            out_negative <= 1'b0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
              a_q[i]   <= in_a[i*N +: N];
              b_q[i]   <= in_b[i*N +: N];
              res_q[i] <= '0;
            end
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          res_q[cnt]   <= alu_result;
          out_zero     <= out_zero & alu_zero;
          out_negative <= out_negative | alu_negative;
          out_carry    <= out_carry | alu_carry;
          out_overflow <= out_overflow | alu_overflow;
          if (cnt == CW'(LANES - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: each combinational output gets a default first so no path infers a latch.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_f = op_q;
    if (state == ISSUE) begin
      alu_a = a_q[cnt];
      alu_b = b_q[cnt];
    end
  end

  always_comb begin
    out_result = '0;
    for (int i = 0; i < LANES; i++) out_result[i*N +: N] = res_q[i];
  end

endmodule

// File: tb/tb_alu_lane_sequencer.sv
// Directed bench for alu_lane_sequencer with a behavioural scalar ALU; vectors carry
// hand-computed results and reduced flags.
module tb_alu_lane_sequencer;

  localparam int N     = 18;
  localparam int LANES = 4;
  localparam int W     = N * LANES;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a, in_b;
  logic [N-1:0] alu_a, alu_b;
  logic [2:0]   alu_f;
  logic [N-1:0] alu_result;
  logic         alu_negative, alu_zero, alu_carry, alu_overflow;
  logic         out_valid, out_ready;
  logic [W-1:0] out_result;
  logic         out_zero, out_negative, out_carry, out_overflow;
  logic         busy;

  always #5 clk = ~clk;

  alu_lane_sequencer #(.N(N), .LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_result(alu_result),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_negative(out_negative), .out_carry(out_carry),
    .out_overflow(out_overflow), .busy(busy)
  );

  // Scalar ALU: 000 add, 001 and, 010/011 A+~B+1, 100 truncated multiply, others xor.
  logic [N:0]     sum;
  logic [2*N-1:0] prod;
  always_comb begin
    sum          = '0;
    prod         = '0;
    alu_result   = alu_a ^ alu_b;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_f)
      3'b000: begin
        sum          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = sum[N-1:0];
        alu_carry    = sum[N];
        alu_overflow = (alu_a[N-1] == alu_b[N-1]) && (sum[N-1] != alu_a[N-1]);
      end
      3'b001: alu_result = alu_a & alu_b;
      3'b010, 3'b011: begin
        sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + 1'b1;
        alu_result   = sum[N-1:0];
        alu_carry    = sum[N];
        alu_overflow = (alu_a[N-1] != alu_b[N-1]) && (sum[N-1] != alu_a[N-1]);
      end
      3'b100: begin
        prod       = alu_a * alu_b;
        alu_result = prod[N-1:0];
        alu_carry  = |prod[2*N-1:N];
      end
      default: alu_result = alu_a ^ alu_b;
    endcase
    alu_zero     = (alu_result == '0);
    alu_negative = alu_result[N-1];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a, b, res;
    logic         z, n, c, v;
  } vec_t;

  function automatic logic [W-1:0] pack(input logic [N-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic vec_t mk(input string name, input logic [2:0] op,
                              input logic [W-1:0] a, b, res,
                              input logic z, n, c, v);
    mk.name = name; mk.op = op; mk.a = a; mk.b = b; mk.res = res;
    mk.z = z; mk.n = n; mk.c = c; mk.v = v;
  endfunction

  task automatic accept(input vec_t v);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = v.op;
    in_a     = v.a;
    in_b     = v.b;
    check({v.name, "_in_ready"}, W'(in_ready), W'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic check_outputs(input vec_t v, input string tag);
    check({v.name, tag, "_result"},   out_result,          v.res);
    check({v.name, tag, "_zero"},     W'(out_zero),     W'(v.z));
    check({v.name, tag, "_negative"}, W'(out_negative), W'(v.n));
    check({v.name, tag, "_carry"},    W'(out_carry),    W'(v.c));
    check({v.name, tag, "_overflow"}, W'(out_overflow), W'(v.v));
  endtask

  // Cycle k is the k-th cycle after the accept edge; out_valid is due in cycle LANES+1.
  task automatic wait_valid(input vec_t v, input bit check_lanes);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (check_lanes && !out_valid && cyc <= LANES) begin
        check({v.name, "_lane_a"},   W'(alu_a),    W'(v.a[(cyc-1)*N +: N]));
        check({v.name, "_lane_b"},   W'(alu_b),    W'(v.b[(cyc-1)*N +: N]));
        check({v.name, "_lane_f"},   W'(alu_f),    W'(v.op));
        check({v.name, "_busy"},     W'(busy),     W'(1));
        check({v.name, "_ready_lo"}, W'(in_ready), W'(0));
      end
    end while (!out_valid && cyc < 20);
    check({v.name, "_latency"}, W'(cyc), W'(LANES + 1));
  endtask

  task automatic run_vec(input vec_t v);
    accept(v);
    wait_valid(v, 1'b1);
    check_outputs(v, "");
    check({v.name, "_busy_done"}, W'(busy), W'(1));
    @(negedge clk);
    check({v.name, "_valid_1cyc"}, W'(out_valid), W'(0));
    check({v.name, "_ready_back"}, W'(in_ready),  W'(1));
    check({v.name, "_idle_busy"},  W'(busy),      W'(0));
    check({v.name, "_held"},       out_result,    v.res);
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  W'(in_ready),  W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_busy",      W'(busy),      W'(0));
    check("rst_result",    out_result,    '0);
    check("rst_flags",     W'({out_zero, out_negative, out_carry, out_overflow}), W'(0));
    check("rst_alu_a",     W'(alu_a),     W'(0));

    vecs[0] = mk("add", 3'b000, pack(1, 2, 3, 4), pack(10, 20, 30, 40),
                 pack(11, 22, 33, 44), 0, 0, 0, 0);
    vecs[1] = mk("sub_zero", 3'b011, pack(7, 7, 7, 7), pack(7, 7, 7, 7), '0, 1, 0, 1, 0);
    vecs[2] = mk("sub_one", 3'b011, pack(7, 7, 7, 8), pack(7, 7, 7, 7),
                 pack(0, 0, 0, 1), 0, 0, 1, 0);
    vecs[3] = mk("mul", 3'b100, pack(3, 300, 1000, 0), pack(5, 300, 1000, 9),
                 pack(15, 90000, 213568, 0), 0, 1, 1, 0);
    vecs[4] = mk("flags", 3'b010, pack(18'h1FFFF, 0, 0, 0), pack(18'h3FFFF, 0, 0, 0),
                 pack(18'h20000, 0, 0, 0), 0, 1, 1, 1);
    vecs[5] = mk("op101", 3'b101, pack(18'hF, 18'h3FFFF, 1, 2), pack(18'hF0, 0, 1, 2),
                 pack(18'hFF, 18'h3FFFF, 0, 0), 0, 1, 0, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Backpressure: hold DONE for three stalled cycles with a second request waiting.
    out_ready = 1'b0;
    accept(vecs[0]);
    wait_valid(vecs[0], 1'b0);
    in_valid = 1'b1; in_op = vecs[1].op; in_a = vecs[1].a; in_b = vecs[1].b;
    for (int k = 0; k < 3; k++) begin
      check("stall_valid",    W'(out_valid), W'(1));
      check("stall_in_ready", W'(in_ready),  W'(0));
      check_outputs(vecs[0], "_stall");
      @(negedge clk);
    end
    check("stall_still_valid", W'(out_valid), W'(1));
    out_ready = 1'b1;
    @(negedge clk);
    check("post_hs_valid", W'(out_valid), W'(0));
    check("post_hs_ready", W'(in_ready),  W'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("held_req_busy",  W'(busy),     W'(1));
    check("held_req_lane0", W'(alu_a),    W'(vecs[1].a[N-1:0]));
    check("held_req_ready", W'(in_ready), W'(0));
    begin
      int cyc = 1;
      while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
      check("held_req_latency", W'(cyc), W'(LANES + 1));
    end
    check_outputs(vecs[1], "_held_req");
    @(negedge clk);

    // Reset while lane 2 is at the ALU: nothing from that instruction may emerge.
    accept(vecs[3]);
    repeat (3) @(negedge clk);
    check("mid_lane2", W'(alu_a), W'(vecs[3].a[2*N +: N]));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid",  W'(out_valid), W'(0));
    check("mid_rst_busy",   W'(busy),      W'(0));
    check("mid_rst_ready",  W'(in_ready),  W'(1));
    check("mid_rst_result", out_result,    '0);
    check("mid_rst_flags",  W'({out_zero, out_negative, out_carry, out_overflow}), W'(0));
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= out_valid | busy;
    end
    check("mid_rst_no_output", W'(seen), W'(0));

    run_vec(vecs[2]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
